fetch_ctl: RTL and testbench
============================

// Module: fetch_ctl
// PURPOSE
//  Sequences instruction fetch into the 4-entry ibuf.
//  - Holds the fetch PC and issues one aligned 8-byte pair request to the I-cache at a time.
//  - Trims the returned pair for entry alignment and taken-branch predictions.
//  - Pushes the surviving instructions into ibuf only when ibuf reports room.
//  - Clears ibuf and restarts fetch on a redirect.
// PARAMETERS
//  RESET_PC  64'h0  fetch PC loaded on reset (bits [1:0] must be 0)
// PORTS
//  clk                  in   1         clock
//  reset                in   1         synchronous, active-high reset
//  fetch_en             in   1         0 blocks new I-cache requests (REQ holds, ic_req=0)
//  redirect             in   1         restart fetch at redirect_pc; highest priority
//  redirect_pc          in   VA_SIZE   new fetch PC (word aligned)
//  ic_req               out  1         I-cache pair request valid
//  ic_req_pc            out  VA_SIZE   {fetch_pc[VA_SIZE-1:3],3'b0}
//  ic_ack               in   1         request accepted this cycle
//  ic_rsp_vld           in   1         pair returned (exactly one per accepted request)
//  ic_rsp_opc_a/b       in   32 each   opcodes at pair_base+0 / pair_base+4
//  bp_taken_a/b         in   1 each    predictor taken flags, valid with ic_rsp_vld
//  bp_target            in   VA_SIZE   predicted target of first taken slot
//  can_accept_1/2       in   1 each    ibuf has room for >=1 / >=2 entries
//  push_a, push_b       out  1 each    ibuf writes; push_a is always older
//  instn_pc_a/b_if      out  VA_SIZE   PCs for ibuf
//  instn_opcode_a/b_if  out  32        opcodes for ibuf
//  instn_pr_taken_a/b_if out 1         prediction flags for ibuf
//  ibuf_clear           out  1         = redirect (combinational)
// BEHAVIOUR
//  - FSM states: REQ, WAIT, PUSH, DRAIN. Reset -> REQ, fetch_pc=RESET_PC, hold regs cleared.
//  - All outputs are 0 in the cycle after reset, except ic_req_pc=RESET_PC.
//  - REQ: ic_req=fetch_en.
//    - ic_req & ic_ack -> WAIT.
//  - WAIT: ic_req=0.
//    - ic_rsp_vld -> capture pair into hold regs, compute slot valids vA/vB -> PUSH.
//    - vA = ~fetch_pc[2].
//    - vB = ~(vA & bp_taken_a).
//    - Next PC = bp_target if (vA&bp_taken_a)|(vB&bp_taken_b); else pair_base+8 (VA_SIZE wrap).
//  - PUSH: n = vA+vB.
//    - Push when (n==2 & can_accept_2) | (n==1 & can_accept_1).
//    - n==2: push_a=A, push_b=B.
//    - n==1: the single slot is driven on port a, push_b=0.
//    - pr_taken flags forwarded per slot. On push: fetch_pc <= next PC -> REQ.
//    - Otherwise hold outputs low and stay. Minimum latency is ic_rsp_vld to push = 1 cycle.
//  - Redirect (any state): ibuf_clear=1.
//    - push_a=push_b=0 and ic_req=0 that cycle; fetch_pc <= redirect_pc.
//    - Next state:
//      - REQ, no ack -> REQ.
//      - REQ with ic_ack -> DRAIN (request was accepted; ic_req forced 0 so ack unexpected, still honoured).
//      - WAIT, no rsp -> DRAIN.
//      - WAIT with ic_rsp_vld -> REQ (rsp dropped).
//      - PUSH -> REQ (hold dropped).
//      - DRAIN -> DRAIN, or REQ if ic_rsp_vld same cycle.
//  - DRAIN: ic_req=0. ic_rsp_vld -> discard and go to REQ; no push ever.
//  - At most one outstanding I-cache request. No push while ibuf_clear=1.
//  - reset dominates redirect.
//  - fetch_en=0 does not stall WAIT/PUSH/DRAIN; it only gates the request in REQ.
// TESTING
//  1 RESET_PC=0, fetch_en=1, ack, rsp A=0x11,B=0x22, can_accept_2=1
//    -> next cycle push_a pc 0x0 opc 0x11, push_b pc 0x4 opc 0x22; then ic_req_pc=0x8.
//  2 redirect_pc=0x104
//    -> ibuf_clear pulse, ic_req_pc=0x100; rsp -> push_a only, pc 0x104 opc=ic_rsp_opc_b; next req 0x108.
//  3 pair 0x8, bp_taken_a=1, bp_target=0x200
//    -> push_a only, pc 0x8, pr_taken_a=1; next ic_req_pc=0x200.
//  4 two valid slots, can_accept_2=0, can_accept_1=1 for 5 cycles
//    -> no push, state PUSH held; can_accept_2=1 -> both pushed that cycle.
//  5 redirect to 0x400 in WAIT, rsp arrives 3 cycles later
//    -> no push of stale pair; next ic_req_pc=0x400 after rsp.
//  6 reset asserted in PUSH -> push_a/b=0, next cycle ic_req=fetch_en at RESET_PC; old hold never pushed.

Source files
------------

// File: rtl/fetch_ctl_if.sv
// Fetch controller bus bundle: fetch control, I-cache request/response,
// branch prediction and ibuf push signals. master = fetch_ctl side.
interface fetch_ctl_if #(
  parameter int VA_SIZE = 64
);
  logic               fetch_en;
  logic               redirect;
  logic [VA_SIZE-1:0] redirect_pc;

  logic               ic_req;
  logic [VA_SIZE-1:0] ic_req_pc;
  logic               ic_ack;
  logic               ic_rsp_vld;
  logic [31:0]        ic_rsp_opc_a;
  logic [31:0]        ic_rsp_opc_b;

  logic               bp_taken_a;
  logic               bp_taken_b;
  logic [VA_SIZE-1:0] bp_target;

  logic               can_accept_1;
  logic               can_accept_2;
  logic               push_a;
  logic               push_b;
  logic [VA_SIZE-1:0] instn_pc_a_if;
  logic [VA_SIZE-1:0] instn_pc_b_if;
  logic [31:0]        instn_opcode_a_if;
  logic [31:0]        instn_opcode_b_if;
  logic               instn_pr_taken_a_if;
  logic               instn_pr_taken_b_if;
  logic               ibuf_clear;

  modport master (
    input  fetch_en, redirect, redirect_pc,
    input  ic_ack, ic_rsp_vld, ic_rsp_opc_a, ic_rsp_opc_b,
    input  bp_taken_a, bp_taken_b, bp_target,
    input  can_accept_1, can_accept_2,
    output ic_req, ic_req_pc,
    output push_a, push_b,
    output instn_pc_a_if, instn_pc_b_if,
    output instn_opcode_a_if, instn_opcode_b_if,
    output instn_pr_taken_a_if, instn_pr_taken_b_if,
    output ibuf_clear
  );

  modport slave (
    output fetch_en, redirect, redirect_pc,
    output ic_ack, ic_rsp_vld, ic_rsp_opc_a, ic_rsp_opc_b,
    output bp_taken_a, bp_taken_b, bp_target,
    output can_accept_1, can_accept_2,
    input  ic_req, ic_req_pc,
    input  push_a, push_b,
    input  instn_pc_a_if, instn_pc_b_if,
    input  instn_opcode_a_if, instn_opcode_b_if,
    input  instn_pr_taken_a_if, instn_pr_taken_b_if,
    input  ibuf_clear
  );
endinterface

// File: rtl/fetch_ctl.sv
// Instruction fetch sequencer: one aligned pair request at a time, trims the
// returned pair for entry alignment / taken predictions and pushes into ibuf.
module fetch_ctl #(
  parameter int                 VA_SIZE  = 64,
  parameter logic [VA_SIZE-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         reset,
  fetch_ctl_if.master bus
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    PUSH  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [VA_SIZE-1:0] PAIR_MASK  = VA_SIZE'(7);
  localparam logic [VA_SIZE-1:0] PAIR_BYTES = VA_SIZE'(8);
  localparam logic [VA_SIZE-1:0] WORD_BYTES = VA_SIZE'(4);

  state_t             state_q, state_d;
  logic [VA_SIZE-1:0] fetch_pc;
  logic [VA_SIZE-1:0] pair_base;

  logic [VA_SIZE-1:0] hold_base;
  logic [VA_SIZE-1:0] hold_next;
  logic [31:0]        hold_opc_a, hold_opc_b;
  logic               hold_tk_a, hold_tk_b;
  logic               hold_va, hold_vb;

  logic               rsp_va, rsp_vb, rsp_taken;
  logic [VA_SIZE-1:0] rsp_next;
  logic               capture, fire, two_slots;

  assign pair_base     = fetch_pc & ~PAIR_MASK;
  assign bus.ic_req_pc = pair_base;

  // Slot A is skipped when entering on the upper word; slot B dies behind a taken A.
  assign rsp_va    = ~fetch_pc[2];
  assign rsp_vb    = ~(rsp_va & bus.bp_taken_a);
  assign rsp_taken = (rsp_va & bus.bp_taken_a) | (rsp_vb & bus.bp_taken_b);
  assign rsp_next  = rsp_taken ? bus.bp_target : pair_base + PAIR_BYTES;
  assign two_slots = hold_va & hold_vb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= REQ;
      fetch_pc   <= RESET_PC;
      hold_base  <= '0;
      hold_next  <= '0;
      hold_opc_a <= '0;
      hold_opc_b <= '0;
      hold_tk_a  <= 1'b0;
      hold_tk_b  <= 1'b0;
      hold_va    <= 1'b0;
      hold_vb    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
      end else if (fire) begin
        fetch_pc <= hold_next;
      end
      if (capture) begin
        hold_base  <= pair_base;
        hold_next  <= rsp_next;
        hold_opc_a <= bus.ic_rsp_opc_a;
        hold_opc_b <= bus.ic_rsp_opc_b;
        hold_tk_a  <= bus.bp_taken_a;
        hold_tk_b  <= bus.bp_taken_b;
        hold_va    <= rsp_va;
        hold_vb    <= rsp_vb;
      end
    end
  end

  // Reset and redirect both silence every request and push in their cycle.
  always_comb begin
    state_d                 = state_q;
    capture                 = 1'b0;
    fire                    = 1'b0;
    bus.ic_req              = 1'b0;
    bus.push_a              = 1'b0;
    bus.push_b              = 1'b0;
    bus.instn_pc_a_if       = '0;
    bus.instn_pc_b_if       = '0;
    bus.instn_opcode_a_if   = '0;
    bus.instn_opcode_b_if   = '0;
    bus.instn_pr_taken_a_if = 1'b0;
    bus.instn_pr_taken_b_if = 1'b0;
    bus.ibuf_clear          = 1'b0;

    if (!reset) begin
      if (bus.redirect) begin
        bus.ibuf_clear = 1'b1;
        case (state_q)
          REQ:     state_d = bus.ic_ack     ? DRAIN : REQ;
          WAIT:    state_d = bus.ic_rsp_vld ? REQ   : DRAIN;
          PUSH:    state_d = REQ;
          DRAIN:   state_d = bus.ic_rsp_vld ? REQ   : DRAIN;
          default: state_d = REQ;
        endcase
      end else begin
        case (state_q)
          REQ: begin
            bus.ic_req = bus.fetch_en;
            if (bus.fetch_en && bus.ic_ack) state_d = WAIT;
          end
          WAIT: begin
            if (bus.ic_rsp_vld) begin
              capture = 1'b1;
              state_d = PUSH;
            end
          end
          PUSH: begin
            if (two_slots ? bus.can_accept_2 : bus.can_accept_1) begin
              fire       = 1'b1;
              bus.push_a = 1'b1;
              state_d    = REQ;
              if (hold_va) begin
                bus.instn_pc_a_if       = hold_base;
                bus.instn_opcode_a_if   = hold_opc_a;
                bus.instn_pr_taken_a_if = hold_tk_a;
              end else begin
                bus.instn_pc_a_if       = hold_base + WORD_BYTES;
                bus.instn_opcode_a_if   = hold_opc_b;
                bus.instn_pr_taken_a_if = hold_tk_b;
              end
              if (two_slots) begin
                bus.push_b              = 1'b1;
                bus.instn_pc_b_if       = hold_base + WORD_BYTES;
                bus.instn_opcode_b_if   = hold_opc_b;
                bus.instn_pr_taken_b_if = hold_tk_b;
              end
            end
          end
          DRAIN: begin
            if (bus.ic_rsp_vld) state_d = REQ;
          end
          default: state_d = REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl: a transaction-level fetch model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_fetch_ctl;

  localparam int          VA  = 64;
  localparam logic [63:0] RPC = 64'h0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_ctl_if #(.VA_SIZE(VA)) bus();
  fetch_ctl #(.VA_SIZE(VA), .RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic fe, input logic ack, input logic rv,
                               input logic [31:0] oa, input logic [31:0] ob,
                               input logic ta, input logic tbk, input logic [63:0] tgt,
                               input logic c1, input logic c2,
                               input logic rd, input logic [63:0] rdpc);
    @(posedge clk);
    #1;
    reset            = rst;
    bus.fetch_en     = fe;
    bus.ic_ack       = ack;
    bus.ic_rsp_vld   = rv;
    bus.ic_rsp_opc_a = oa;
    bus.ic_rsp_opc_b = ob;
    bus.bp_taken_a   = ta;
    bus.bp_taken_b   = tbk;
    bus.bp_target    = tgt;
    bus.can_accept_1 = c1;
    bus.can_accept_2 = c2;
    bus.redirect     = rd;
    bus.redirect_pc  = rdpc;
    @(negedge clk);
  endtask

  task automatic req(input logic ack);
    applyStimulus(0, 1, ack, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
  endtask

  task automatic rsp(input logic [31:0] oa, input logic [31:0] ob, input logic ta,
                     input logic tbk, input logic [63:0] tgt);
    applyStimulus(0, 1, 0, 1, oa, ob, ta, tbk, tgt, 1, 1, 0, 0);
  endtask

  task automatic redir(input logic [63:0] rdpc, input logic ack, input logic rv);
    applyStimulus(0, 0, ack, rv, 0, 0, 0, 0, 0, 1, 1, 1, rdpc);
  endtask

  task automatic room(input logic c1, input logic c2, input logic fe);
    applyStimulus(0, fe, 0, 0, 0, 0, 0, 0, 0, c1, c2, 0, 0);
  endtask

  // Fetch model: outstanding request, stale flag and a list of surviving slots.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] opc;
    logic        tk;
  } slot_t;

  slot_t       pend[$];
  logic [63:0] m_pc   = RPC;
  logic [63:0] m_next = '0;
  bit          m_out  = 0;
  bit          m_stale = 0;

  always @(negedge clk) begin : model
    logic        e_req, e_pa, e_pb, e_clr, e_tka, e_tkb, taken;
    logic [63:0] e_pca, e_pcb, base;
    logic [31:0] e_opa, e_opb;
    slot_t       s;
    e_req = 0; e_pa = 0; e_pb = 0; e_clr = 0; e_tka = 0; e_tkb = 0;
    e_pca = '0; e_pcb = '0; e_opa = '0; e_opb = '0;
    if (!reset) begin
      if (bus.redirect) begin
        e_clr = 1;
      end else begin
        e_req = bus.fetch_en && !m_out && pend.size() == 0;
        if (pend.size() > 0 && (pend.size() == 2 ? bus.can_accept_2 : bus.can_accept_1)) begin
          e_pa = 1; e_pca = pend[0].pc; e_opa = pend[0].opc; e_tka = pend[0].tk;
          if (pend.size() == 2) begin
            e_pb = 1; e_pcb = pend[1].pc; e_opb = pend[1].opc; e_tkb = pend[1].tk;
          end
        end
      end
      checkOutput("m_ic_req_pc", bus.ic_req_pc, {m_pc[63:3], 3'b000});
    end
    checkOutput("m_ic_req", 64'(bus.ic_req), 64'(e_req));
    checkOutput("m_ibuf_clear", 64'(bus.ibuf_clear), 64'(e_clr));
    checkOutput("m_push_a", 64'(bus.push_a), 64'(e_pa));
    checkOutput("m_push_b", 64'(bus.push_b), 64'(e_pb));
    checkOutput("m_pc_a", bus.instn_pc_a_if, e_pca);
    checkOutput("m_pc_b", bus.instn_pc_b_if, e_pcb);
    checkOutput("m_opc_a", 64'(bus.instn_opcode_a_if), 64'(e_opa));
    checkOutput("m_opc_b", 64'(bus.instn_opcode_b_if), 64'(e_opb));
    checkOutput("m_tk_a", 64'(bus.instn_pr_taken_a_if), 64'(e_tka));
    checkOutput("m_tk_b", 64'(bus.instn_pr_taken_b_if), 64'(e_tkb));

    if (reset) begin
      m_pc = RPC; m_out = 0; m_stale = 0; pend.delete();
    end else if (bus.redirect) begin
      if (m_out) begin
        if (bus.ic_rsp_vld) begin m_out = 0; m_stale = 0; end
        else m_stale = 1;
      end else if (pend.size() == 0 && bus.ic_ack) begin
        m_out = 1; m_stale = 1;
      end
      pend.delete();
      m_pc = bus.redirect_pc;
    end else if (e_pa) begin
      m_pc = m_next;
      pend.delete();
    end else if (m_out && bus.ic_rsp_vld) begin
      m_out = 0;
      if (!m_stale) begin
        base  = {m_pc[63:3], 3'b000};
        taken = 0;
        if (!m_pc[2]) begin
          s.pc = base; s.opc = bus.ic_rsp_opc_a; s.tk = bus.bp_taken_a;
          pend.push_back(s);
          taken = bus.bp_taken_a;
        end
        if (!taken) begin
          s.pc = base + 64'd4; s.opc = bus.ic_rsp_opc_b; s.tk = bus.bp_taken_b;
          pend.push_back(s);
          taken = bus.bp_taken_b;
        end
        m_next = taken ? bus.bp_target : base + 64'd8;
      end
      m_stale = 0;
    end else if (!m_out && pend.size() == 0 && bus.fetch_en && bus.ic_ack) begin
      m_out = 1;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, expected $finish first");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.fetch_en = 0; bus.ic_ack = 0; bus.ic_rsp_vld = 0;
    bus.ic_rsp_opc_a = 0; bus.ic_rsp_opc_b = 0; bus.bp_taken_a = 0; bus.bp_taken_b = 0;
    bus.bp_target = 0; bus.can_accept_1 = 0; bus.can_accept_2 = 0;
    bus.redirect = 0; bus.redirect_pc = 0;

    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("rst_ic_req", 64'(bus.ic_req), 0);
    checkOutput("rst_push_a", 64'(bus.push_a), 0);
    checkOutput("rst_req_pc", bus.ic_req_pc, 64'h0);

    // 1: aligned pair, both slots pushed
    req(1);
    checkOutput("t1_ic_req", 64'(bus.ic_req), 1);
    checkOutput("t1_req_pc", bus.ic_req_pc, 64'h0);
    rsp(32'h11, 32'h22, 0, 0, 0);
    checkOutput("t1_wait_req", 64'(bus.ic_req), 0);
    room(1, 1, 1);
    checkOutput("t1_push_a", 64'(bus.push_a), 1);
    checkOutput("t1_pc_a", bus.instn_pc_a_if, 64'h0);
    checkOutput("t1_opc_a", 64'(bus.instn_opcode_a_if), 64'h11);
    checkOutput("t1_push_b", 64'(bus.push_b), 1);
    checkOutput("t1_pc_b", bus.instn_pc_b_if, 64'h4);
    checkOutput("t1_opc_b", 64'(bus.instn_opcode_b_if), 64'h22);
    req(0);
    checkOutput("t1_next_pc", bus.ic_req_pc, 64'h8);

    // 2: redirect to upper word, only slot B survives
    redir(64'h104, 0, 0);
    checkOutput("t2_clear", 64'(bus.ibuf_clear), 1);
    checkOutput("t2_req_off", 64'(bus.ic_req), 0);
    req(1);
    checkOutput("t2_req_pc", bus.ic_req_pc, 64'h100);
    rsp(32'hAAAA0001, 32'hBBBB0002, 0, 0, 0);
    room(1, 1, 1);
    checkOutput("t2_push_a", 64'(bus.push_a), 1);
    checkOutput("t2_pc_a", bus.instn_pc_a_if, 64'h104);
    checkOutput("t2_opc_a", 64'(bus.instn_opcode_a_if), 64'hBBBB0002);
    checkOutput("t2_push_b", 64'(bus.push_b), 0);
    req(0);
    checkOutput("t2_next_pc", bus.ic_req_pc, 64'h108);

    // 3: taken slot A kills slot B and steers to the target
    redir(64'h8, 0, 0);
    req(1);
    checkOutput("t3_req_pc", bus.ic_req_pc, 64'h8);
    rsp(32'h33, 32'h44, 1, 0, 64'h200);
    room(1, 1, 1);
    checkOutput("t3_push_a", 64'(bus.push_a), 1);
    checkOutput("t3_pc_a", bus.instn_pc_a_if, 64'h8);
    checkOutput("t3_tk_a", 64'(bus.instn_pr_taken_a_if), 1);
    checkOutput("t3_push_b", 64'(bus.push_b), 0);
    req(0);
    checkOutput("t3_next_pc", bus.ic_req_pc, 64'h200);

    // 4: two slots wait for room for two
    req(1);
    rsp(32'h55, 32'h66, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      room(1, 0, 1);
      checkOutput("t4_hold_push_a", 64'(bus.push_a), 0);
    end
    room(1, 1, 1);
    checkOutput("t4_push_a", 64'(bus.push_a), 1);
    checkOutput("t4_pc_a", bus.instn_pc_a_if, 64'h200);
    checkOutput("t4_push_b", 64'(bus.push_b), 1);
    checkOutput("t4_opc_b", 64'(bus.instn_opcode_b_if), 64'h66);

    // 5: redirect while waiting, stale pair arrives later and is dropped
    req(1);
    checkOutput("t5_req_pc", bus.ic_req_pc, 64'h208);
    redir(64'h400, 0, 0);
    checkOutput("t5_clear", 64'(bus.ibuf_clear), 1);
    room(1, 1, 1);
    checkOutput("t5_drain_req", 64'(bus.ic_req), 0);
    room(1, 1, 1);
    rsp(32'h77, 32'h88, 0, 0, 0);
    checkOutput("t5_no_push", 64'(bus.push_a), 0);
    req(0);
    checkOutput("t5_no_push2", 64'(bus.push_a), 0);
    checkOutput("t5_req", 64'(bus.ic_req), 1);
    checkOutput("t5_req_pc2", bus.ic_req_pc, 64'h400);

    // 6: reset in PUSH drops the held pair
    req(1);
    rsp(32'h99, 32'hAA, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("t6_push_a", 64'(bus.push_a), 0);
    checkOutput("t6_push_b", 64'(bus.push_b), 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("t6_req", 64'(bus.ic_req), 1);
    checkOutput("t6_req_pc", bus.ic_req_pc, 64'h0);
    room(1, 1, 0);
    checkOutput("t6_stale_push", 64'(bus.push_a), 0);

    // 7: entry at upper word with a taken slot B
    redir(64'h4, 0, 0);
    req(1);
    rsp(32'hC1, 32'hC2, 1, 1, 64'h300);
    room(1, 1, 1);
    checkOutput("t7_pc_a", bus.instn_pc_a_if, 64'h4);
    checkOutput("t7_opc_a", 64'(bus.instn_opcode_a_if), 64'hC2);
    checkOutput("t7_tk_a", 64'(bus.instn_pr_taken_a_if), 1);
    checkOutput("t7_push_b", 64'(bus.push_b), 0);
    req(0);
    checkOutput("t7_next_pc", bus.ic_req_pc, 64'h300);

    // 8: fetch_en gating, then redirect with the response in the same cycle
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("t8_gated", 64'(bus.ic_req), 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    req(1);
    checkOutput("t8_req", 64'(bus.ic_req), 1);
    redir(64'h500, 0, 1);
    checkOutput("t8_clear", 64'(bus.ibuf_clear), 1);
    checkOutput("t8_push", 64'(bus.push_a), 0);
    req(0);
    checkOutput("t8_req2", 64'(bus.ic_req), 1);
    checkOutput("t8_req_pc", bus.ic_req_pc, 64'h500);

    // 9: sequential PC wraps at the top of the address space
    redir(64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
    req(1);
    rsp(32'hD1, 32'hD2, 0, 0, 0);
    room(1, 1, 1);
    checkOutput("t9_pc_a", bus.instn_pc_a_if, 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("t9_pc_b", bus.instn_pc_b_if, 64'hFFFF_FFFF_FFFF_FFFC);
    req(0);
    checkOutput("t9_wrap_pc", bus.ic_req_pc, 64'h0);

    room(1, 1, 0);
    room(1, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
